// File: rtl/piano_pkg.sv
// Shared codes for the MiniPiano note path: note/mode encodings, ROM word
// layout and the song sequencer state type.
package piano_pkg;

  typedef enum logic [3:0] {
    NOTE_REST = 4'd0,
    NOTE_DO   = 4'd1,
    NOTE_RE   = 4'd2,
    NOTE_MI   = 4'd3,
    NOTE_FA   = 4'd4,
    NOTE_SOL  = 4'd5,
    NOTE_LA   = 4'd6,
    NOTE_SI   = 4'd7
  } note_t;

  typedef enum logic [2:0] {
    MODE_FREE = 3'b000,
    MODE_AUTO = 3'b001
  } mode_t;

  localparam int NOTE_MSB = 7;
  localparam int NOTE_LSB = 4;
  localparam int DUR_MSB  = 3;
  localparam int DUR_LSB  = 0;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, GAP, DONE} seq_state_t;

  // Lowest pressed key wins; returns 1..7, or rest when nothing is pressed.
  function automatic logic [3:0] lowest_key(input logic [6:0] keys);
    lowest_key = NOTE_REST;
    for (int i = 6; i >= 0; i--)
      if (keys[i]) lowest_key = 4'(i + 1);
  endfunction

  function automatic logic [6:0] note_led(input logic [3:0] note);
    note_led = '0;
    if (note >= NOTE_DO && note <= NOTE_SI) note_led = 7'b1 << (note - NOTE_DO);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Duration tick prescaler: counts 0..TICK_CYC-1 and pulses tick on the last
// count; restart returns the count to 0 so a new duration starts aligned.
module tick_gen #(
  parameter int TICK_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int CNT_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(TICK_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || restart || tick) cnt <= '0;
    else                        cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/song_sequencer.sv
// Buzzer note path: live keyboard in free mode, song ROM playback in auto mode.
// Build option SONG_LOOP_EN: songs restart from word 0 instead of stopping.
//
//   state | meaning
//   IDLE  | free play, keyboard drives note_out/led_out
//   FETCH | rom_addr = {song_idx, ptr} presented to the ROM
//   WAIT  | ROM word arrives; end marker or start of a note
//   PLAY  | note sounding for dur ticks
//   GAP   | silence for GAP_TICKS ticks, then advance ptr
//   DONE  | song finished, silent until song change or mode exit
module song_sequencer
  import piano_pkg::*;
#(
  parameter  int CLK_HZ    = 100_000_000,
  parameter  int TICK_HZ   = 16,
  parameter  int NUM_SONGS = 4,
  parameter  int SONG_LEN  = 64,
  parameter  int GAP_TICKS = 1,
  localparam int SIDX_W    = $clog2(NUM_SONGS),
  localparam int PTR_W     = $clog2(SONG_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              keys,
  input  logic [2:0]              mode,
  input  logic [1:0]              song_select,
  output logic [SIDX_W+PTR_W-1:0] rom_addr,
  input  logic [7:0]              rom_data,
  output logic [3:0]              note_out,
  output logic [6:0]              led_out,
  output logic [SIDX_W-1:0]       song_idx,
  output logic                    playing
);
  localparam int TICK_CYC = CLK_HZ / TICK_HZ;
  localparam int REM_W    = (GAP_TICKS > 15) ? $clog2(GAP_TICKS + 1) : 4;

  seq_state_t        state;
  logic [PTR_W-1:0]  ptr;
  logic [REM_W-1:0]  rem;
  logic [1:0]        sel_q, sel_rise;
  logic              change, tick, restart, last_tick, last_word;
  logic [SIDX_W-1:0] next_idx;
  logic [3:0]        rom_note, rom_dur;

  assign rom_note  = rom_data[NOTE_MSB:NOTE_LSB];
  assign rom_dur   = rom_data[DUR_MSB:DUR_LSB];
  assign sel_rise  = song_select & ~sel_q;
  assign change    = sel_rise[0] ^ sel_rise[1];
  assign next_idx  = sel_rise[0] ? song_idx + SIDX_W'(1) : song_idx - SIDX_W'(1);
  assign last_tick = tick && (rem == REM_W'(1));
  assign last_word = (ptr == PTR_W'(SONG_LEN - 1));
  assign restart   = (state == WAIT) || (state == PLAY && last_tick);
  assign rom_addr  = {song_idx, ptr};
  assign playing   = (state == FETCH) || (state == WAIT) || (state == PLAY) || (state == GAP);

  tick_gen #(.TICK_CYC(TICK_CYC)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      rem      <= '0;
      sel_q    <= '0;
      song_idx <= '0;
      note_out <= '0;
      led_out  <= '0;
    end else begin
      sel_q <= song_select;
      if (change) song_idx <= next_idx;

      if (mode != MODE_AUTO) begin
        state    <= IDLE;
        ptr      <= '0;
        note_out <= lowest_key(keys);
        led_out  <= keys;
      end else if (change || state == IDLE) begin
        state    <= FETCH;
        ptr      <= '0;
        note_out <= '0;
        led_out  <= '0;
      end else begin
        case (state)
          FETCH: state <= WAIT;
          WAIT: begin
            if (rom_dur == '0) begin
`ifdef SONG_LOOP_EN
              // Only an empty song (marker at word 0) can park in DONE.
              if (ptr != '0) begin
                state <= FETCH;
                ptr   <= '0;
              end else state <= DONE;
`else
              state <= DONE;
`endif
            end else begin
              rem      <= REM_W'(rom_dur);
              note_out <= rom_note;
              led_out  <= note_led(rom_note);
              state    <= PLAY;
            end
          end
          PLAY, GAP: begin
            if (tick && !last_tick) rem <= rem - REM_W'(1);
            if (last_tick) begin
              note_out <= '0;
              led_out  <= '0;
              if (state == PLAY && GAP_TICKS != 0) begin
                rem   <= REM_W'(GAP_TICKS);
                state <= GAP;
              end else if (last_word) begin
`ifdef SONG_LOOP_EN
                state <= FETCH;
                ptr   <= '0;
`else
                state <= DONE;
`endif
              end else begin
                ptr   <= ptr + PTR_W'(1);
                state <= FETCH;
              end
            end
          end
          default: begin
            note_out <= '0;
            led_out  <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a cycle-stamped expectation scoreboard.
module tb_song_sequencer;
  localparam int SIG_NOTE = 0, SIG_LED = 1, SIG_IDX = 2, SIG_PLAY = 3, SIG_ADDR = 4;

  logic       clk, rst;
  logic [6:0] keys;
  logic [2:0] mode;
  logic [1:0] song_select;
  logic [4:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] note_out;
  logic [6:0] led_out;
  logic [1:0] song_idx;
  logic       playing;

  logic [7:0] rom [0:31];

  song_sequencer #(
    .CLK_HZ(16), .TICK_HZ(4), .NUM_SONGS(4), .SONG_LEN(8), .GAP_TICKS(1)
  ) dut (
    .clk(clk), .rst(rst), .keys(keys), .mode(mode), .song_select(song_select),
    .rom_addr(rom_addr), .rom_data(rom_data), .note_out(note_out),
    .led_out(led_out), .song_idx(song_idx), .playing(playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      SIG_NOTE: return 32'(note_out);
      SIG_LED:  return 32'(led_out);
      SIG_IDX:  return 32'(song_idx);
      SIG_PLAY: return 32'(playing);
      default:  return 32'(rom_addr);
    endcase
  endfunction

  task automatic expect_at(input int t, input int sig, input logic [31:0] val, input string name);
    exp_t e;
    e.t = t; e.sig = sig; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic at_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: pops every expectation due this cycle and compares it.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].t <= cyc) begin
        checks++;
        if (actual(sb[i].sig) !== sb[i].val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%0h expected=%0h", sb[i].name, cyc,
                   actual(sb[i].sig), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_reset(input int t);
    expect_at(t, SIG_NOTE, 0, "rst_note");
    expect_at(t, SIG_LED,  0, "rst_led");
    expect_at(t, SIG_IDX,  0, "rst_idx");
    expect_at(t, SIG_PLAY, 0, "rst_playing");
    expect_at(t, SIG_ADDR, 0, "rst_addr");
  endtask

  int b, c1, f, g;

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    rom[0] = 8'h32; rom[1] = 8'h01; rom[2] = 8'h50;
    for (int i = 8; i < 16; i++) rom[i] = 8'h11;
    rom[24] = 8'h64;
    rst = 1'b1; mode = 3'b000; keys = '0; song_select = '0;

    @(negedge clk);
    b = cyc;
    expect_reset(b + 1);
    at_cyc(b + 2);
    rst = 1'b0;

    // Free play
    b = cyc;
    keys = 7'b0010100;
    expect_at(b + 1, SIG_NOTE, 3, "free_note_3");
    expect_at(b + 1, SIG_LED, 7'b0010100, "free_led");
    at_cyc(b + 1);
    keys = 7'b1111000;
    expect_at(b + 2, SIG_NOTE, 4, "free_note_4");
    at_cyc(b + 2);
    keys = '0;
    song_select = 2'b01;
    expect_at(b + 3, SIG_NOTE, 0, "free_note_0");
    expect_at(b + 3, SIG_LED, 0, "free_led_0");
    expect_at(b + 3, SIG_IDX, 1, "free_next_song");
    at_cyc(b + 3);
    song_select = 2'b00;
    at_cyc(b + 4);
    song_select = 2'b10;
    expect_at(b + 5, SIG_IDX, 0, "free_prev_song");
    expect_at(b + 5, SIG_PLAY, 0, "free_not_playing");
    at_cyc(b + 5);
    song_select = 2'b00;

    // Auto play of song 0: note 3 x2 ticks, rest x1 tick, end marker
    at_cyc(b + 6);
    b = cyc;
    mode = 3'b001;
    expect_at(b + 1, SIG_PLAY, 1, "auto_fetch_playing");
    expect_at(b + 1, SIG_ADDR, 0, "auto_addr0");
    expect_at(b + 2, SIG_NOTE, 0, "auto_wait_silent");
    for (int k = 3; k <= 10; k++) expect_at(b + k, SIG_NOTE, 3, "auto_note3_held");
    expect_at(b + 3, SIG_LED, 7'b0000100, "auto_led_onehot");
    for (int k = 11; k <= 26; k++) expect_at(b + k, SIG_NOTE, 0, "auto_gap_rest_silent");
    expect_at(b + 11, SIG_LED, 0, "auto_gap_led");
    expect_at(b + 15, SIG_ADDR, 1, "auto_addr1");
    expect_at(b + 25, SIG_ADDR, 2, "auto_addr2");
    expect_at(b + 26, SIG_PLAY, 1, "auto_wait_marker_playing");
`ifdef SONG_LOOP_EN
    expect_at(b + 27, SIG_ADDR, 0, "loop_marker_refetch");
    expect_at(b + 27, SIG_PLAY, 1, "loop_marker_playing");
`else
    expect_at(b + 27, SIG_PLAY, 0, "auto_done_playing");
    expect_at(b + 30, SIG_PLAY, 0, "auto_done_hold");
    expect_at(b + 30, SIG_NOTE, 0, "auto_done_note");
`endif
    at_cyc(b + 31);

    // Re-enter auto, change song mid-PLAY
    b = cyc;
    mode = 3'b000;
    at_cyc(b + 1);
    mode = 3'b001;
    c1 = b + 1;
    for (int k = 3; k <= 5; k++) expect_at(c1 + k, SIG_NOTE, 3, "replay_note3");
    expect_at(c1 + 6, SIG_IDX, 1, "midplay_next_idx");
    expect_at(c1 + 6, SIG_ADDR, 8, "midplay_fetch_addr");
    expect_at(c1 + 6, SIG_NOTE, 0, "midplay_fetch_silent");
    expect_at(c1 + 6, SIG_PLAY, 1, "midplay_playing");
    at_cyc(c1 + 5);
    song_select = 2'b01;
    at_cyc(c1 + 6);
    song_select = 2'b00;
    f = c1 + 6;

    // Song 1: eight 1-tick notes, no end marker
    expect_at(f + 2, SIG_NOTE, 1, "song1_first_note");
    at_cyc(f + 22);
    song_select = 2'b11;
    for (int k = 23; k <= 25; k++) expect_at(f + k, SIG_NOTE, 1, "both_edges_note_kept");
    expect_at(f + 23, SIG_IDX, 1, "both_edges_idx");
    expect_at(f + 24, SIG_ADDR, 10, "both_edges_addr");
    expect_at(f + 26, SIG_NOTE, 0, "both_edges_gap");
    expect_at(f + 30, SIG_ADDR, 11, "both_edges_advance");
    at_cyc(f + 23);
    song_select = 2'b00;
    expect_at(f + 70, SIG_ADDR, 15, "song1_last_word");
    expect_at(f + 72, SIG_NOTE, 1, "song1_last_note");
    expect_at(f + 79, SIG_PLAY, 1, "song1_last_gap");
`ifdef SONG_LOOP_EN
    expect_at(f + 80, SIG_ADDR, 8, "loop_wrap_addr");
    expect_at(f + 80, SIG_PLAY, 1, "loop_wrap_playing");
`else
    expect_at(f + 80, SIG_PLAY, 0, "song1_done");
    expect_at(f + 80, SIG_ADDR, 15, "song1_done_addr");
`endif

    // Previous-song wrap 0 -> 3
    g = f + 84;
    at_cyc(g);
    song_select = 2'b10;
    expect_at(g + 1, SIG_IDX, 0, "prev_to_0");
    at_cyc(g + 1);
    song_select = 2'b00;
    at_cyc(g + 2);
    song_select = 2'b10;
    expect_at(g + 3, SIG_IDX, 3, "prev_wrap_3");
    expect_at(g + 3, SIG_ADDR, 24, "prev_wrap_addr");
    at_cyc(g + 3);
    song_select = 2'b00;
    for (int k = 5; k <= 8; k++) expect_at(g + k, SIG_NOTE, 6, "song3_note6");
    expect_at(g + 5, SIG_LED, 7'b0100000, "song3_led");

    // Reset mid-PLAY, with a song change arriving in the same cycle
    at_cyc(g + 8);
    rst = 1'b1;
    song_select = 2'b01;
    expect_reset(g + 9);
    at_cyc(g + 9);
    rst = 1'b0;
    song_select = 2'b00;
    expect_at(g + 12, SIG_NOTE, 3, "post_rst_song0_note");
    expect_at(g + 12, SIG_IDX, 0, "post_rst_idx");
    expect_at(g + 12, SIG_PLAY, 1, "post_rst_playing");

    // Leave auto mode mid-note
    at_cyc(g + 13);
    mode = 3'b000;
    keys = 7'b1000000;
    expect_at(g + 14, SIG_NOTE, 7, "exit_auto_note");
    expect_at(g + 14, SIG_LED, 7'b1000000, "exit_auto_led");
    expect_at(g + 14, SIG_PLAY, 0, "exit_auto_playing");
    expect_at(g + 14, SIG_ADDR, 0, "exit_auto_ptr");
    at_cyc(g + 14);
    keys = 7'b0000011;
    expect_at(g + 15, SIG_NOTE, 1, "exit_auto_follow");
    expect_at(g + 15, SIG_LED, 7'b0000011, "exit_auto_follow_led");

    at_cyc(g + 20);
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard_drain left=%0d", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview: Controls the shared buzzer note path. In free mode it forwards the live keyboard to the buzzer. In auto mode it walks a song ROM and times each note and rest. It sits between the keys/mode/song_select inputs and the Buzzer and Led instances in MiniPiano, replacing direct keyboard drive of the note bus.

Parameters:
CLK_HZ, 100_000_000, system clock frequency
TICK_HZ, 16, duration tick rate; TICK_CYC = CLK_HZ/TICK_HZ clocks per tick
NUM_SONGS, 4, songs in ROM; must be a power of 2; SIDX_W = clog2(NUM_SONGS)
SONG_LEN, 64, ROM words per song; must be a power of 2; PTR_W = clog2(SONG_LEN)
GAP_TICKS, 1, silent ticks inserted after every note

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
keys  in  7  piano keys, bit0 = do ... bit6 = si, level-sensitive
mode  in  3  3'b001 = auto play; every other value = free play
song_select  in  2  bit0 = next song, bit1 = previous song; raw level, edge-detected internally
rom_addr  out  SIDX_W+PTR_W  {song_idx, ptr}; synchronous ROM returns data one cycle later
rom_data  in  8  ROM word: [7:4] note (0 = rest, 1..7 = do..si), [3:0] duration in ticks (0 = end marker)
note_out  out  4  note to Buzzer; 0 = silent
led_out  out  7  LED drive
song_idx  out  SIDX_W  currently selected song
playing  out  1  high while in FETCH/WAIT/PLAY/GAP

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: note_out=0, led_out=0, song_idx=0, playing=0, rom_addr=0, ptr=0, state=IDLE, edge-detect registers=0.
- Free play (mode!=3'b001):
  - note_out is registered, 1-cycle latency from keys.
  - note_out = index+1 of the lowest set key bit; 0 if no key is pressed.
  - led_out = keys, registered.
  - FSM is held in IDLE.
- Entering auto mode (mode becomes 3'b001 while in IDLE): next cycle goes to FETCH with ptr=0.
- FSM states, one per clock unless noted:
  - FETCH: rom_addr={song_idx,ptr}; go to WAIT.
  - WAIT: sample rom_data.
    - dur==0 -> DONE.
    - else latch note and dur, load the remaining-tick counter with dur, restart the prescaler, go to PLAY.
  - PLAY: note_out = latched note.
    - Counter decrements on each tick; the state lasts exactly dur*TICK_CYC cycles.
    - At 0, load GAP_TICKS, restart the prescaler, go to GAP.
    - If GAP_TICKS==0, go straight to the advance step.
  - GAP: note_out=0; lasts GAP_TICKS*TICK_CYC cycles. Then advance:
    - ptr==SONG_LEN-1 -> DONE (no wrap-around play).
    - else ptr+1 -> FETCH.
  - DONE: note_out=0, playing=0; holds until a song change or mode exit.
- Auto-mode LEDs: led_out is one-hot on the latched note (note n lights bit n-1) in PLAY; 0 in all other states.
- Song change: on a rising edge of song_select[0], song_idx+1 mod NUM_SONGS; on a rising edge of song_select[1], song_idx-1 mod NUM_SONGS (0 -> NUM_SONGS-1).
  - Both edges in the same cycle: ignored, no change.
  - In auto mode, any applied change forces FETCH with ptr=0 on the next cycle from any state. Takes priority over the tick/advance logic in that cycle.
  - In free mode, only song_idx updates.
- Leaving auto mode mid-song: next cycle state=IDLE, playing=0, ptr=0; note_out follows keys from the following cycle.
- Tick prescaler: counts 0..TICK_CYC-1; the tick pulse fires in the cycle the count reaches TICK_CYC-1; restarts on every counter load.
- rst overrides everything, including in-progress song changes.

Optional Feature:
SONG_LOOP_EN:
- Defined: a DONE condition (end marker or ptr==SONG_LEN-1) goes to FETCH with ptr=0, so the song repeats indefinitely. DONE is unreachable except via an end marker at ptr 0, which holds DONE.
- Undefined: the song stops in DONE as described above.

Decomposition:
- Package piano_pkg:
  - note codes NOTE_REST=0, NOTE_DO..NOTE_SI=1..7
  - mode codes MODE_FREE=3'b000, MODE_AUTO=3'b001
  - ROM field positions NOTE_MSB=7, NOTE_LSB=4, DUR_MSB=3, DUR_LSB=0
  - state enum seq_state_t {IDLE, FETCH, WAIT, PLAY, GAP, DONE}
- Sub-module tick_gen (param TICK_CYC; ports clk, rst, restart, tick). Counter and edge detectors stay inline.

Test Plan (sim params CLK_HZ=16, TICK_HZ=4 -> TICK_CYC=4, GAP_TICKS=1, SONG_LEN=8):
- Free mode, keys=7'b0010100 -> note_out=3 one cycle later and led_out=7'b0010100; keys=0 -> note_out=0.
- Auto mode, song0 ROM = {0x32, 0x01, 0x50, ...}:
  - note 3 held for exactly 8 cycles, then 0 for 4 cycles;
  - then note_out=0 for 4 cycles (rest) plus a 4-cycle gap;
  - then the end marker -> DONE, playing=0.
- Pulse song_select[0] mid-PLAY in auto mode -> song_idx=1; next cycle FETCH, rom_addr={1,0}. From song_idx=0, pulse song_select[1] -> song_idx=3.
- Both select bits rise in the same cycle -> song_idx unchanged, playback uninterrupted.
- Song with no end marker over 8 words -> DONE after ptr=7. With SONG_LOOP_EN -> rom_addr returns to {idx,0} and replays.
- Assert rst during PLAY -> next cycle all outputs 0, state IDLE. Switch mode to free mid-note -> note_out follows keys within 2 cycles.
